// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - fetch PC owner: branch/jump/jr redirect, stall hold, halt, flushes
// Priority: EX branch > stall > ID jump > ID jr > ID halt > PC+4.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Stall,
  input  logic             BranchTaken_EX,
  input  logic [31:0]      BranchTarget_EX,
  input  logic             Jump_ID,
  input  logic [25:0]      Target26_ID,
  input  logic [31:0]      PC4_ID,
  input  logic             JumpReg_ID,
  input  logic [31:0]      RegTarget_ID,
  input  logic             Halt_ID,
  output logic [31:0]      PC,
  output logic             IF_Flush,
  output logic             ID_Flush,
  output logic             Halted,
  output logic             AlignErr,
  output logic [CNT_W-1:0] RedirectCnt
);

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             align_q;
  logic [CNT_W-1:0] cnt_q;
  logic             redirect;
  logic             set_align;
  logic             if_flush, id_flush;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    redirect  = 1'b0;
    set_align = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    // Flushes are suppressed while Rst is high; the register update ignores this block then.
    if (state_q == RUN && !Rst) begin
      if (BranchTaken_EX) begin
        pc_d     = BranchTarget_EX;
        if_flush = 1'b1;
        id_flush = 1'b1;
        redirect = 1'b1;
      end else if (Stall) begin
        pc_d = pc_q;
      end else if (Jump_ID) begin
        pc_d     = {PC4_ID[31:28], Target26_ID, 2'b00};
        if_flush = 1'b1;
        redirect = 1'b1;
      end else if (JumpReg_ID) begin
        pc_d      = {RegTarget_ID[31:2], 2'b00};
        if_flush  = 1'b1;
        redirect  = 1'b1;
        set_align = (RegTarget_ID[1:0] != 2'b00);
      end else if (Halt_ID) begin
        pc_d     = pc_q;
        if_flush = 1'b1;
        state_d  = HALTED;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      align_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (set_align) align_q <= 1'b1;
      if (redirect && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign PC          = pc_q;
  assign IF_Flush    = if_flush;
  assign ID_Flush    = id_flush;
  assign Halted      = (state_q == HALTED);
  assign AlignErr    = align_q;
  assign RedirectCnt = cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - table-driven directed bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;

  logic        Clk = 1'b0;
  logic        Rst, Stall, BranchTaken_EX, Jump_ID, JumpReg_ID, Halt_ID;
  logic [31:0] BranchTarget_EX, PC4_ID, RegTarget_ID;
  logic [25:0] Target26_ID;
  logic [31:0] PC, PC_s;
  logic        IF_Flush, ID_Flush, Halted, AlignErr;
  logic        IF_Flush_s, ID_Flush_s, Halted_s, AlignErr_s;
  logic [15:0] RedirectCnt;
  logic [1:0]  RedirectCnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  pc_redirect_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .BranchTaken_EX(BranchTaken_EX),
    .BranchTarget_EX(BranchTarget_EX), .Jump_ID(Jump_ID), .Target26_ID(Target26_ID),
    .PC4_ID(PC4_ID), .JumpReg_ID(JumpReg_ID), .RegTarget_ID(RegTarget_ID), .Halt_ID(Halt_ID),
    .PC(PC), .IF_Flush(IF_Flush), .ID_Flush(ID_Flush), .Halted(Halted),
    .AlignErr(AlignErr), .RedirectCnt(RedirectCnt)
  );

  // Narrow counter copy sharing the same stimulus, to reach saturation quickly.
  pc_redirect_ctrl #(.RESET_PC(32'h0), .CNT_W(2)) dut_sat (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .BranchTaken_EX(BranchTaken_EX),
    .BranchTarget_EX(BranchTarget_EX), .Jump_ID(Jump_ID), .Target26_ID(Target26_ID),
    .PC4_ID(PC4_ID), .JumpReg_ID(JumpReg_ID), .RegTarget_ID(RegTarget_ID), .Halt_ID(Halt_ID),
    .PC(PC_s), .IF_Flush(IF_Flush_s), .ID_Flush(ID_Flush_s), .Halted(Halted_s),
    .AlignErr(AlignErr_s), .RedirectCnt(RedirectCnt_s)
  );

  typedef struct {
    logic        rst, stall, br, jmp, jr, halt;
    logic [31:0] btgt, pc4, rtgt;
    logic [25:0] t26;
    logic [31:0] epc;
    logic        eif, eid, ehalt, eal;
    int          ecnt;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl[NV];

  function automatic vec_t mk(logic rst, logic stall, logic br, logic [31:0] btgt,
                              logic jmp, logic [31:0] pc4, logic [25:0] t26,
                              logic jr, logic [31:0] rtgt, logic halt,
                              logic [31:0] epc, logic eif, logic eid, logic ehalt,
                              logic eal, int ecnt);
    vec_t v;
    v.rst = rst; v.stall = stall; v.br = br; v.btgt = btgt; v.jmp = jmp; v.pc4 = pc4;
    v.t26 = t26; v.jr = jr; v.rtgt = rtgt; v.halt = halt; v.epc = epc; v.eif = eif;
    v.eid = eid; v.ehalt = ehalt; v.eal = eal; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    Rst = v.rst; Stall = v.stall; BranchTaken_EX = v.br; BranchTarget_EX = v.btgt;
    Jump_ID = v.jmp; PC4_ID = v.pc4; Target26_ID = v.t26; JumpReg_ID = v.jr;
    RegTarget_ID = v.rtgt; Halt_ID = v.halt;
  endtask

  initial begin
    vec_t idle;
    int   sat;
    //             rst st br btgt          jmp pc4           t26        jr rtgt          hlt  epc           if id hl al cnt
    tbl[0]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        26'h0,     0, 32'h0,        0,   32'h0,        0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        26'h0,     0, 32'h0,        0,   32'h4,        0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        26'h0,     0, 32'h0,        0,   32'h8,        0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        26'h0,     0, 32'h0,        0,   32'hC,        0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 32'h0,        1, 32'hA000_0010, 26'h123,  0, 32'h0,        0,   32'h10,       1, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        26'h0,     0, 32'h0,        0,   32'hA000_048C, 0, 0, 0, 0, 1);
    tbl[6]  = mk(0, 1, 1, 32'h200,      1, 32'hA000_0010, 26'h123,  0, 32'h0,        0,   32'hA000_0490, 1, 1, 0, 0, 1);
    tbl[7]  = mk(0, 0, 1, 32'h40,       0, 32'h0,        26'h0,     0, 32'h0,        0,   32'h200,      1, 1, 0, 0, 2);
    tbl[8]  = mk(0, 1, 0, 32'h0,        1, 32'h44,       26'h100,   0, 32'h0,        0,   32'h40,       0, 0, 0, 0, 3);
    tbl[9]  = mk(0, 1, 0, 32'h0,        1, 32'h44,       26'h100,   0, 32'h0,        0,   32'h40,       0, 0, 0, 0, 3);
    tbl[10] = mk(0, 1, 0, 32'h0,        1, 32'h44,       26'h100,   0, 32'h0,        0,   32'h40,       0, 0, 0, 0, 3);
    tbl[11] = mk(0, 0, 0, 32'h0,        1, 32'h44,       26'h100,   0, 32'h0,        0,   32'h40,       1, 0, 0, 0, 3);
    tbl[12] = mk(0, 0, 0, 32'h0,        0, 32'h0,        26'h0,     1, 32'h1003,     0,   32'h400,      1, 0, 0, 0, 4);
    tbl[13] = mk(0, 0, 0, 32'h0,        0, 32'h0,        26'h0,     0, 32'h0,        0,   32'h1000,     0, 0, 0, 1, 5);
    tbl[14] = mk(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,       26'h0,     0, 32'h0,        0,   32'h1004,     1, 1, 0, 1, 5);
    tbl[15] = mk(0, 0, 0, 32'h0,        0, 32'h0,        26'h0,     0, 32'h0,        0,   32'hFFFF_FFFC, 0, 0, 0, 1, 6);
    tbl[16] = mk(0, 0, 0, 32'h0,        0, 32'h0,        26'h0,     0, 32'h0,        1,   32'h0,        1, 0, 0, 1, 6);
    tbl[17] = mk(0, 0, 0, 32'h0,        1, 32'h44,       26'h100,   0, 32'h0,        0,   32'h0,        0, 0, 1, 1, 6);
    tbl[18] = mk(0, 0, 1, 32'h300,      1, 32'h44,       26'h100,   0, 32'h0,        0,   32'h0,        0, 0, 1, 1, 6);
    tbl[19] = mk(0, 0, 0, 32'h0,        1, 32'h44,       26'h100,   1, 32'h800,      1,   32'h0,        0, 0, 1, 1, 6);
    tbl[20] = mk(0, 0, 0, 32'h0,        1, 32'h44,       26'h100,   0, 32'h0,        0,   32'h0,        0, 0, 1, 1, 6);
    tbl[21] = mk(0, 0, 0, 32'h0,        1, 32'h44,       26'h100,   0, 32'h0,        0,   32'h0,        0, 0, 1, 1, 6);
    tbl[22] = mk(1, 0, 1, 32'h300,      0, 32'h0,        26'h0,     0, 32'h0,        0,   32'h0,        0, 0, 1, 1, 6);
    tbl[23] = mk(0, 0, 0, 32'h0,        0, 32'h0,        26'h0,     0, 32'h0,        0,   32'h0,        0, 0, 0, 0, 0);
    tbl[24] = mk(0, 0, 0, 32'h0,        1, 32'h10,       26'h40,    1, 32'h800,      0,   32'h4,        1, 0, 0, 0, 0);
    tbl[25] = mk(0, 0, 0, 32'h0,        0, 32'h0,        26'h0,     0, 32'h0,        0,   32'h100,      0, 0, 0, 0, 1);
    idle = mk(0, 0, 0, 32'h0, 0, 32'h0, 26'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 0);

    drive(idle);
    Rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d pc", i), PC, tbl[i].epc);
      chk($sformatf("v%0d if_flush", i), {31'b0, IF_Flush}, {31'b0, tbl[i].eif});
      chk($sformatf("v%0d id_flush", i), {31'b0, ID_Flush}, {31'b0, tbl[i].eid});
      chk($sformatf("v%0d halted", i), {31'b0, Halted}, {31'b0, tbl[i].ehalt});
      chk($sformatf("v%0d align_err", i), {31'b0, AlignErr}, {31'b0, tbl[i].eal});
      chk($sformatf("v%0d redirect_cnt", i), {16'b0, RedirectCnt}, tbl[i].ecnt);
      sat = (tbl[i].ecnt > 3) ? 3 : tbl[i].ecnt;
      chk($sformatf("v%0d sat_cnt", i), {30'b0, RedirectCnt_s}, sat);
      @(negedge Clk);
    end

    // Aligned jr must not raise AlignErr.
    drive(idle);
    JumpReg_ID = 1'b1; RegTarget_ID = 32'h0000_2000;
    @(negedge Clk);
    drive(idle);
    #1;
    chk("jr aligned pc", PC, 32'h2000);
    chk("jr aligned align_err", {31'b0, AlignErr}, 32'h0);
    chk("jr aligned cnt", {16'b0, RedirectCnt}, 32'h2);

    // Reset coinciding with a branch: no flush, reset wins.
    drive(idle);
    Rst = 1'b1; BranchTaken_EX = 1'b1; BranchTarget_EX = 32'h0000_0800;
    #1;
    chk("rst+branch if_flush", {31'b0, IF_Flush}, 32'h0);
    chk("rst+branch id_flush", {31'b0, ID_Flush}, 32'h0);
    @(negedge Clk);
    drive(idle);
    #1;
    chk("rst+branch pc", PC, 32'h0);
    chk("rst+branch cnt", {16'b0, RedirectCnt}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
